// File: rtl/det_pkg.sv
// Shared definitions for determinant-engine controllers: FSM encoding and
// width helpers for flattened matrices and requester indices.
package det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } det_state_t;

  function automatic int mat_width(input int n, input int dw);
    return n * n * dw;
  endfunction

  function automatic int idx_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr+1 (mod NUM_REQ), as a one-hot vector and as an index.
module rr_arbiter
  import det_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               found
);

  int unsigned idx;

  // NOTE: every output gets a default before the search so no path through
  // the loop leaves a value unassigned and infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/det_scheduler.sv
// Round-robin scheduler sharing one determinant engine between NUM_REQ
// requesters, with restart handshake sequencing and a LOAD/RUN watchdog.
module det_scheduler
  import det_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int BIN_POS     = 16,
  parameter  int MATRIX_SIZE = 3,
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT     = 4096,
  localparam int MW          = mat_width(MATRIX_SIZE, DATA_WIDTH),
  localparam int IW          = idx_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*MW-1:0] req_matrix,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_det,
  output logic                  rsp_timeout,
  output logic                  eng_rst,
  input  logic                  eng_ready,
  input  logic                  eng_complete,
  output logic [MW-1:0]         eng_matrix,
  input  logic [DATA_WIDTH-1:0] eng_det,
  output logic                  busy
);

  localparam int WDW = $clog2(TIMEOUT);

  if (NUM_REQ < 2) begin : g_chk_num_req
    $error("det_scheduler: NUM_REQ must be at least 2");
  end
  if (TIMEOUT < 4) begin : g_chk_timeout
    $error("det_scheduler: TIMEOUT must be at least 4");
  end
  if (BIN_POS >= DATA_WIDTH) begin : g_chk_bin_pos
    $error("det_scheduler: BIN_POS must lie inside DATA_WIDTH");
  end

  det_state_t         state, state_d;
  logic [IW-1:0]      ptr;
  logic [WDW-1:0]     wd;
  logic               state_entry;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_found;
  logic               active, wd_expired, run_done, timed_out;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .found     (grant_found)
  );

  // state_entry marks the first cycle of a state, where a stale eng_ready or
  // eng_complete left over from the previous job must be ignored.
  assign active     = (state == LOAD) || (state == RUN);
  assign wd_expired = (wd == WDW'(TIMEOUT - 1));
  assign run_done   = (state == RUN) && !state_entry && eng_complete;
  assign timed_out  = active && wd_expired && !run_done;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (grant_found) state_d = LOAD;
      LOAD: begin
        if (timed_out)                      state_d = RESP;
        else if (!state_entry && eng_ready) state_d = RUN;
      end
      RUN:  if (run_done || timed_out) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst so the grant pulse stays low while reset is held.
  assign req_ready = (rst && state == IDLE) ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign eng_rst   = (state == LOAD) || (state == RESP && rsp_timeout);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= IW'(NUM_REQ - 1);
      wd          <= '0;
      state_entry <= 1'b0;
      eng_matrix  <= '0;
      rsp_id      <= '0;
      rsp_det     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      state_entry <= (state_d != state);
      if (state == IDLE && grant_found) begin
        eng_matrix <= req_matrix[grant_idx*MW +: MW];
        rsp_id     <= grant_idx;
        ptr        <= grant_idx;
        wd         <= '0;
      end else if (active) begin
        wd <= wd + WDW'(1);
      end
      if (run_done) begin
        rsp_det     <= eng_det;
        rsp_timeout <= 1'b0;
      end else if (timed_out) begin
        rsp_det     <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_det_scheduler.sv
// Scoreboard bench for det_scheduler: directed requests against a simple
// diagonal-matrix engine model, with grant and response monitors.
module tb_det_scheduler;

  localparam int DW  = 32;
  localparam int N   = 3;
  localparam int NR  = 4;
  localparam int TO  = 16;
  localparam int MW  = N * N * DW;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] det;
    logic          to;
  } exp_rsp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*MW-1:0]  req_matrix;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_det;
  logic              rsp_timeout;
  logic              eng_rst;
  logic              eng_ready = 1'b0;
  logic              eng_complete = 1'b0;
  logic [MW-1:0]     eng_matrix;
  logic [DW-1:0]     eng_det;
  logic              busy;

  int       checks = 0;
  int       errors = 0;
  exp_rsp_t exp_rsp_q[$];
  int       exp_grant_q[$];
  bit       stale_mode = 1'b0;
  bit       hang_mode = 1'b0;
  int       run_cnt = 0;

  det_scheduler #(
    .DATA_WIDTH (DW), .BIN_POS (16), .MATRIX_SIZE (N),
    .NUM_REQ (NR), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_matrix (req_matrix), .req_ready (req_ready),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_id (rsp_id),
    .rsp_det (rsp_det), .rsp_timeout (rsp_timeout),
    .eng_rst (eng_rst), .eng_ready (eng_ready), .eng_complete (eng_complete),
    .eng_matrix (eng_matrix), .eng_det (eng_det), .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mk_diag(input logic [DW-1:0] v);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*DW +: DW] = v;
    return m;
  endfunction

  // Engine model: fixed-point product of the diagonal (exact for diagonal inputs).
  function automatic logic [DW-1:0] diag_det(input logic [MW-1:0] m);
    longint p;
    p = longint'($signed(m[0 +: DW]));
    for (int i = 1; i < N; i++)
      p = (p * longint'($signed(m[(i*N+i)*DW +: DW]))) >>> 16;
    return p[DW-1:0];
  endfunction

  assign eng_det = diag_det(eng_matrix);

  always @(posedge clk) begin
    eng_ready    <= stale_mode ? 1'b1 : eng_rst;
    run_cnt      <= eng_rst ? 0 : run_cnt + 1;
    eng_complete <= stale_mode || (!hang_mode && !eng_rst && run_cnt >= 1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   req_ready, 0);
    check({tag, "_rsp_valid"},   rsp_valid, 0);
    check({tag, "_rsp_id"},      rsp_id, 0);
    check({tag, "_rsp_det"},     rsp_det, 0);
    check({tag, "_rsp_timeout"}, rsp_timeout, 0);
    check({tag, "_eng_rst"},     eng_rst, 0);
    check({tag, "_eng_matrix"},  eng_matrix == '0, 1);
    check({tag, "_busy"},        busy, 0);
  endtask

  // Grant monitor
  always @(negedge clk) begin
    if (rst && req_ready != '0) begin
      if (exp_grant_q.size() == 0) check("grant_unexpected", req_ready, 0);
      else check("grant_onehot", req_ready, 64'(1) << exp_grant_q.pop_front());
    end
  end

  // Response monitor
  exp_rsp_t e;
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_rsp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
      else begin
        e = exp_rsp_q.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_det", rsp_det, e.det);
        check("rsp_timeout", rsp_timeout, e.to);
      end
    end
  end

  task automatic wait_grant();
    int n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) check("grant_wait_expired", |req_ready, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (n < 300 && !(exp_rsp_q.size() == 0 && exp_grant_q.size() == 0 && !busy)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_wait_expired", exp_rsp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    int k, gcnt, load_n, run_n;
    bit stable, nogrant, busy_ok, rst_ok;
    logic [1:0]    snap_id;
    logic [DW-1:0] snap_det;
    logic          snap_to;

    req_matrix = {mk_diag(32'h0005_0000), mk_diag(32'h0001_0000),
                  mk_diag(32'h0003_0000), mk_diag(32'h0002_0000)};

    // Reset state
    @(negedge clk);
    check_reset_outputs("init");
    @(posedge clk); #1;
    rst = 1'b1;

    // Single request, requester 2 with the identity matrix
    exp_grant_q.push_back(2);
    exp_rsp_q.push_back('{id: 2'd2, det: 32'h0001_0000, to: 1'b0});
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_grant();
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    // All four requesting from reset: grants 0,1,2,3,0
    do_reset();
    exp_grant_q = '{0, 1, 2, 3, 0};
    exp_rsp_q.push_back('{id: 2'd0, det: 32'h0008_0000, to: 1'b0});
    exp_rsp_q.push_back('{id: 2'd1, det: 32'h001B_0000, to: 1'b0});
    exp_rsp_q.push_back('{id: 2'd2, det: 32'h0001_0000, to: 1'b0});
    exp_rsp_q.push_back('{id: 2'd3, det: 32'h007D_0000, to: 1'b0});
    exp_rsp_q.push_back('{id: 2'd0, det: 32'h0008_0000, to: 1'b0});
    @(posedge clk); #1;
    req_valid = 4'b1111;
    gcnt = 0;
    for (int i = 0; i < 400 && gcnt < 5; i++) begin
      @(negedge clk);
      if (req_ready != '0) gcnt++;
    end
    check("rr_grant_count", gcnt, 5);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    // Stale ready/complete engine: LOAD and RUN each last two cycles
    stale_mode = 1'b1;
    exp_grant_q.push_back(1);
    exp_rsp_q.push_back('{id: 2'd1, det: 32'h001B_0000, to: 1'b0});
    @(posedge clk); #1;
    req_valid = 4'b0010;
    wait_grant();
    load_n = 0;
    run_n = 0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      if (eng_matrix !== mk_diag(32'h0003_0000)) stable = 1'b0;
      if (rsp_valid) break;
      if (eng_rst) load_n++;
      else if (busy) run_n++;
    end
    check("stale_load_cycles", load_n, 2);
    check("stale_run_cycles", run_n, 2);
    check("eng_matrix_stable", stable, 1);
    wait_drain();
    stale_mode = 1'b0;

    // Hung engine: watchdog abort, then backpressure and back-to-back grant
    hang_mode = 1'b1;
    exp_grant_q.push_back(3);
    exp_rsp_q.push_back('{id: 2'd3, det: 32'h0000_0000, to: 1'b1});
    exp_grant_q.push_back(0);
    exp_rsp_q.push_back('{id: 2'd0, det: 32'h0008_0000, to: 1'b0});
    @(posedge clk); #1;
    req_valid = 4'b1000;
    wait_grant();
    @(posedge clk); #1;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("load_entry_eng_rst", eng_rst, 1);
    k = 0;
    while (!rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, 16);
    check("timeout_flag", rsp_timeout, 1);
    check("timeout_det_zero", rsp_det, 0);
    hang_mode = 1'b0;
    snap_id = rsp_id;
    snap_det = rsp_det;
    snap_to = rsp_timeout;
    stable = 1'b1;
    nogrant = 1'b1;
    busy_ok = 1'b1;
    rst_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== snap_id || rsp_det !== snap_det ||
          rsp_timeout !== snap_to) stable = 1'b0;
      if (req_ready !== '0) nogrant = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (eng_rst !== 1'b1) rst_ok = 1'b0;
    end
    check("bp_outputs_stable", stable, 1);
    check("bp_no_grant", nogrant, 1);
    check("bp_busy", busy_ok, 1);
    check("bp_eng_rst_held", rst_ok, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("b2b_grant_next_cycle", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    // Reset during RUN discards the job; first grant afterwards is requester 0
    exp_grant_q.push_back(2);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_grant();
    @(posedge clk); #1;
    req_valid = '0;
    k = 0;
    while (!(busy && !eng_rst && !rsp_valid) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("reached_run", busy && !eng_rst, 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_async");
    req_valid = 4'b1001;
    @(negedge clk);
    check_reset_outputs("rst_held");
    exp_grant_q.push_back(0);
    exp_rsp_q.push_back('{id: 2'd0, det: 32'h0008_0000, to: 1'b0});
    exp_grant_q.push_back(3);
    exp_rsp_q.push_back('{id: 2'd3, det: 32'h007D_0000, to: 1'b0});
    @(posedge clk); #1;
    rst = 1'b1;
    wait_grant();
    @(posedge clk); #1;
    req_valid = 4'b1000;
    wait_grant();
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    check("grant_queue_empty", exp_grant_q.size(), 0);
    check("rsp_queue_empty", exp_rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
